// File: rtl/dpc_pkg.sv
// Shared definitions for the bad-pixel stream mapper: mode encoding, table entry layout, geometry defaults.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package dpc_pkg;

  typedef enum logic [1:0] {
    BYPASS  = 2'd0,
    FLAG    = 2'd1,
    REPLACE = 2'd2
  } dpc_mode_e;

  // Table entry layout: {col[31:16], row[15:0]}
  localparam int POS_W         = 16;
  localparam int ENTRY_W       = 32;
  localparam int ENTRY_ROW_LSB = 0;
  localparam int ENTRY_COL_LSB = 16;

  // Default frame geometry
  localparam int DEF_ROW         = 288;
  localparam int DEF_COL         = 384;
  localparam int DEF_TDATA_WIDTH = 14;
  localparam int DEF_MAX_BAD     = 64;

  // The reserved encoding behaves like flag-only.
  function automatic dpc_mode_e decode_mode(input logic [1:0] mode);
    case (mode)
      2'd0:    return BYPASS;
      2'd2:    return REPLACE;
      default: return FLAG;
    endcase
  endfunction

  // Raster-ordered key {row, col} so entries compare as plain unsigned numbers.
  function automatic logic [2*POS_W-1:0] entry_raster(input logic [ENTRY_W-1:0] entry);
    return {entry[ENTRY_ROW_LSB +: POS_W], entry[ENTRY_COL_LSB +: POS_W]};
  endfunction

endpackage

// File: rtl/bad_pixel_stream_mapper_table.sv
// Bad-pixel position table: MAX_BAD x 32 register file, one write port, one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational (a same-cycle write is seen next cycle).
// Backpressure: none; contents are deliberately not reset so the table survives stream resets.
module bad_pixel_table
  import dpc_pkg::*;
#(
  parameter int  MAX_BAD = DEF_MAX_BAD,
  localparam int AW      = $clog2(MAX_BAD)
) (
  input  logic               axis_aclk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [MAX_BAD];

  // Single write port, no reset.
  always_ff @(posedge axis_aclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bad_pixel_stream_mapper.sv
// Tracks raster position of an AXI-Stream video feed, flags/replaces pixels listed in a bad-pixel table.
// Latency: exactly one accepted beat through a single output register.
// Backpressure: s_axis_tready = m_axis_tready | ~m_axis_tvalid; the held beat stays stable while stalled.
module bad_pixel_stream_mapper
  import dpc_pkg::*;
#(
  parameter int  ROW              = DEF_ROW,
  parameter int  COL              = DEF_COL,
  parameter int  AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int  MAX_BAD          = DEF_MAX_BAD,
  localparam int AW               = $clog2(MAX_BAD)
) (
  input  logic                        axis_aclk,
  input  logic                        axis_areset,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tuser,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tbad,
  input  logic                        cfg_wr_en,
  input  logic [AW-1:0]               cfg_wr_addr,
  input  logic [31:0]                 cfg_wr_data,
  input  logic [AW:0]                 cfg_num,
  input  logic [1:0]                  cfg_mode,
  output logic [AW:0]                 stat_bad_cnt,
  output logic                        stat_len_err
);

  localparam int                CW       = AW + 1;
  localparam logic [CW-1:0]     MAX_CNT  = CW'(MAX_BAD);
  localparam logic [POS_W-1:0]  LAST_ROW = POS_W'(ROW - 1);
  localparam logic [POS_W-1:0]  LAST_COL = POS_W'(COL - 1);

  // Frame state
  logic [POS_W-1:0]            row_q, col_q;
  logic [CW-1:0]               ptr_q, frame_num_q, match_cnt_q;
  dpc_mode_e                   frame_mode_q;
  logic [AXIS_TDATA_WIDTH-1:0] last_pix_q;

  // Per-beat view: a tuser beat overrides all frame state (frame start or abort)
  logic                        accept;
  logic [POS_W-1:0]            cur_row, cur_col;
  logic [CW-1:0]               cur_ptr, cur_num, match_cnt_nxt;
  dpc_mode_e                   cur_mode;
  logic [ENTRY_W-1:0]          tbl_rd_data;
  logic [2*POS_W-1:0]          ent_pos, cur_pos;
  logic                        in_range, hit, behind, is_bad, len_bad;
  logic [AXIS_TDATA_WIDTH-1:0] out_data;

  assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
  assign accept        = s_axis_tvalid & s_axis_tready;

  bad_pixel_table #(
    .MAX_BAD (MAX_BAD)
  ) u_table (
    .axis_aclk (axis_aclk),
    .wr_en     (cfg_wr_en),
    .wr_addr   (cfg_wr_addr),
    .wr_data   (cfg_wr_data),
    .rd_addr   (cur_ptr[AW-1:0]),
    .rd_data   (tbl_rd_data)
  );

  // Position, table compare and output pixel selection for the beat on the input.
  always_comb begin
    cur_row  = s_axis_tuser ? '0 : row_q;
    cur_col  = s_axis_tuser ? '0 : col_q;
    cur_ptr  = s_axis_tuser ? '0 : ptr_q;
    cur_mode = s_axis_tuser ? decode_mode(cfg_mode) : frame_mode_q;
    cur_num  = frame_num_q;
    if (s_axis_tuser) begin
      cur_num = (cfg_num > MAX_CNT) ? MAX_CNT : cfg_num;
    end

    ent_pos  = entry_raster(tbl_rd_data);
    cur_pos  = {cur_row, cur_col};
    in_range = cur_ptr < cur_num;
    hit      = in_range && (ent_pos == cur_pos);
    behind   = in_range && (ent_pos < cur_pos);
    is_bad   = hit && (cur_mode != BYPASS);

    out_data = s_axis_tdata;
    if (is_bad && (cur_mode == REPLACE) && (cur_col != '0)) begin
      out_data = last_pix_q;
    end

    match_cnt_nxt = s_axis_tuser ? '0 : match_cnt_q;
    if (is_bad && (match_cnt_nxt != MAX_CNT)) begin
      match_cnt_nxt = match_cnt_nxt + CW'(1);
    end

    len_bad = s_axis_tlast ? (cur_col != LAST_COL) : (cur_col == LAST_COL);
  end

  // Output register: load on accept, drop valid once the consumer takes the beat.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tbad   <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= out_data;
      m_axis_tuser  <= s_axis_tuser;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tbad   <= is_bad;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Frame bookkeeping: counters, table pointer, frame config, match count and status.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      row_q        <= '0;
      col_q        <= '0;
      ptr_q        <= '0;
      frame_num_q  <= '0;
      frame_mode_q <= BYPASS;
      match_cnt_q  <= '0;
      last_pix_q   <= '0;
      stat_bad_cnt <= '0;
      stat_len_err <= 1'b0;
    end else if (accept) begin
      frame_mode_q <= cur_mode;
      frame_num_q  <= cur_num;
      ptr_q        <= (hit || behind) ? cur_ptr + CW'(1) : cur_ptr;
      match_cnt_q  <= match_cnt_nxt;
      last_pix_q   <= out_data;
      if (s_axis_tlast) begin
        col_q <= '0;
        row_q <= (cur_row == LAST_ROW) ? cur_row : cur_row + POS_W'(1);
      end else begin
        col_q <= cur_col + POS_W'(1);
        row_q <= cur_row;
      end
      if (s_axis_tlast && (cur_row == LAST_ROW)) begin
        stat_bad_cnt <= match_cnt_nxt;
      end
      if (len_bad) begin
        stat_len_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bad_pixel_stream_mapper.sv
// Randomised self-checking bench for bad_pixel_stream_mapper against a beat-level reference model.
// Latency: n/a (bench drives and samples on the falling edge).
// Backpressure: random m_axis_tready and s_axis_tvalid duty in selected frames.
module tb_bad_pixel_stream_mapper;

  localparam int ROW     = 88;
  localparam int COL     = 160;
  localparam int W       = 14;
  localparam int MAX_BAD = 16;
  localparam int AW      = 4;
  localparam int NW      = AW + 1;

  logic          axis_aclk, axis_areset;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [W-1:0]  s_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast, m_axis_tbad;
  logic [W-1:0]  m_axis_tdata;
  logic          cfg_wr_en;
  logic [AW-1:0] cfg_wr_addr;
  logic [31:0]   cfg_wr_data;
  logic [NW-1:0] cfg_num;
  logic [1:0]    cfg_mode;
  logic [NW-1:0] stat_bad_cnt;
  logic          stat_len_err;

  bad_pixel_stream_mapper #(
    .ROW (ROW), .COL (COL), .AXIS_TDATA_WIDTH (W), .MAX_BAD (MAX_BAD)
  ) dut (
    .axis_aclk     (axis_aclk),
    .axis_areset   (axis_areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tbad   (m_axis_tbad),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_data   (cfg_wr_data),
    .cfg_num       (cfg_num),
    .cfg_mode      (cfg_mode),
    .stat_bad_cnt  (stat_bad_cnt),
    .stat_len_err  (stat_len_err)
  );

  initial begin
    axis_aclk = 1'b0;
    forever #5 axis_aclk = ~axis_aclk;
  end

  typedef struct { int data; bit user; bit last; int mode; int num; } in_beat_t;
  typedef struct { int data; bit user; bit last; bit bad; int row; int col; int fid; } exp_beat_t;

  in_beat_t  in_q[$];
  exp_beat_t exp_q[$];

  // Reference table and model state
  int tbl_r [MAX_BAD];
  int tbl_c [MAX_BAD];
  int m_row, m_col, m_ptr, m_num, m_mode, m_cnt, m_prev, m_stat;
  bit m_len_err;

  // Observations
  bit bad_seen [5][ROW][COL];
  int obs_b    [ROW][COL];
  int bad_cnt_obs [5];
  int raw_10_0;

  int n_checks, n_pass;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: one input beat -> expected output beat, from position/table rules.
  task automatic model_beat(input in_beat_t b, input int fid);
    exp_beat_t e;
    longint    ent, pos;
    bit        hit;
    if (b.user) begin
      m_row = 0; m_col = 0; m_ptr = 0; m_cnt = 0;
      m_num  = (b.num > MAX_BAD) ? MAX_BAD : b.num;
      m_mode = (b.mode == 3) ? 1 : b.mode;
    end
    hit = 0;
    if (m_ptr < m_num) begin
      ent = longint'(tbl_r[m_ptr]) * 65536 + tbl_c[m_ptr];
      pos = longint'(m_row) * 65536 + m_col;
      if (ent == pos) begin hit = 1; m_ptr++; end
      else if (ent < pos) m_ptr++;
    end
    e.bad  = hit && (m_mode != 0);
    e.data = (e.bad && m_mode == 2 && m_col > 0) ? m_prev : b.data;
    e.user = b.user; e.last = b.last; e.row = m_row; e.col = m_col; e.fid = fid;
    exp_q.push_back(e);
    m_prev = e.data;
    if (e.bad && m_cnt < MAX_BAD) m_cnt++;
    if (b.last ? (m_col != COL - 1) : (m_col == COL - 1)) m_len_err = 1;
    if (b.last && m_row == ROW - 1) m_stat = m_cnt;
    if (b.last) begin
      m_col = 0;
      if (m_row < ROW - 1) m_row++;
    end else begin
      m_col++;
    end
  endtask

  // kind: 0 random, 1 ramp, 2 random with rows 82/83 = column index
  task automatic gen_frame(input int fid, input int mode, input int num, input int rows,
                           input int kind, input int short_row);
    for (int r = 0; r < rows; r++) begin
      int len;
      len = (r == short_row) ? 101 : COL;
      for (int c = 0; c < len; c++) begin
        in_beat_t b;
        b.data = (kind == 1) ? ((r * COL + c) & 16'h3fff) : int'($urandom_range(16383));
        if (kind == 2 && (r == 82 || r == 83)) b.data = c;
        b.user = (r == 0 && c == 0);
        b.last = (c == len - 1);
        b.mode = mode;
        b.num  = num;
        if (fid == 1 && r == 10 && c == 0) raw_10_0 = b.data;
        in_q.push_back(b);
        model_beat(b, fid);
      end
    end
  endtask

  task automatic write_entry(input int idx, input int r, input int c);
    @(negedge axis_aclk);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = idx[AW-1:0];
    cfg_wr_data = {c[15:0], r[15:0]};
    @(negedge axis_aclk);
    cfg_wr_en = 1'b0;
    tbl_r[idx] = r;
    tbl_c[idx] = c;
  endtask

  task automatic check_out();
    exp_beat_t e;
    longint    exp_v, got_v;
    if (exp_q.size() == 0) begin
      check_val("extra_out_beat", 1, 0);
    end else begin
      e = exp_q.pop_front();
      got_v = {m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tbad};
      exp_v = (longint'(e.data) << 3) | (longint'(e.user) << 2) | (longint'(e.last) << 1) | longint'(e.bad);
      check_val($sformatf("beat f%0d r%0d c%0d {data,user,last,bad}", e.fid, e.row, e.col), got_v, exp_v);
      if (m_axis_tbad) bad_cnt_obs[e.fid]++;
      bad_seen[e.fid][e.row][e.col] = m_axis_tbad;
      if (e.fid == 1) obs_b[e.row][e.col] = int'(m_axis_tdata);
    end
  endtask

  // Stream the queued beats with random handshake duty, checking every output transfer.
  task automatic run_phase(input int ready_pct, input int valid_pct);
    int limit, cyc;
    limit = 4 * in_q.size() + 200;
    cyc   = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < limit) begin
      @(negedge axis_aclk);
      cyc++;
      m_axis_tready = ($urandom_range(99) < ready_pct);
      cfg_mode      = 2'($urandom_range(3));
      cfg_num       = NW'($urandom_range(MAX_BAD));
      if (in_q.size() > 0 && $urandom_range(99) < valid_pct) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = W'(in_q[0].data);
        s_axis_tuser  = in_q[0].user;
        s_axis_tlast  = in_q[0].last;
        if (in_q[0].user) begin
          cfg_mode = 2'(in_q[0].mode);
          cfg_num  = NW'(in_q[0].num);
        end
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = W'($urandom);
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      cfg_wr_en   = ($urandom_range(7) == 0);
      cfg_wr_addr = AW'($urandom_range(15, 8));
      cfg_wr_data = $urandom;
      #1;
      if (m_axis_tvalid && m_axis_tready) check_out();
      if (s_axis_tvalid && s_axis_tready) void'(in_q.pop_front());
    end
    if (cyc >= limit) begin
      check_val("phase_timeout_beats_left", in_q.size() + exp_q.size(), 0);
      in_q.delete();
      exp_q.delete();
    end
    @(negedge axis_aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_wr_en     = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge axis_aclk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  int pos_r [5] = '{29, 82, 82, 83, 83};
  int pos_c [5] = '{156, 132, 133, 132, 133};

  initial begin
    n_checks = 0; n_pass = 0;
    m_row = 0; m_col = 0; m_ptr = 0; m_num = 0; m_mode = 0; m_cnt = 0; m_prev = 0;
    m_stat = 0; m_len_err = 0;
    axis_areset   = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; cfg_num = '0; cfg_mode = 2'd0;
    repeat (3) @(negedge axis_aclk);
    #1;
    check_val("rst_m_tvalid", m_axis_tvalid, 0);
    check_val("rst_m_tdata", m_axis_tdata, 0);
    check_val("rst_m_tuser_tlast_tbad", {m_axis_tuser, m_axis_tlast, m_axis_tbad}, 0);
    check_val("rst_stat_bad_cnt", stat_bad_cnt, 0);
    check_val("rst_stat_len_err", stat_len_err, 0);
    check_val("rst_s_tready", s_axis_tready, 1);
    axis_areset = 1'b0;

    // Frame A: flag mode, ramp image, five sorted entries
    for (int i = 0; i < 5; i++) write_entry(i, pos_r[i], pos_c[i]);
    gen_frame(0, 1, 5, ROW, 1, -1);
    run_phase(100, 100);
    check_val("A_stat_bad_cnt", stat_bad_cnt, 5);
    check_val("A_stat_vs_model", stat_bad_cnt, m_stat);
    check_val("A_len_err", stat_len_err, 0);
    check_val("A_tbad_beats", bad_cnt_obs[0], 5);
    for (int i = 0; i < 5; i++)
      check_val($sformatf("A_tbad_at_%0d_%0d", pos_r[i], pos_c[i]), bad_seen[0][pos_r[i]][pos_c[i]], 1);

    // Frame B: replace mode, (10,0) prepended, random ready/valid
    write_entry(0, 10, 0);
    for (int i = 0; i < 5; i++) write_entry(i + 1, pos_r[i], pos_c[i]);
    gen_frame(1, 2, 6, ROW, 2, -1);
    run_phase(50, 90);
    check_val("B_stat_bad_cnt", stat_bad_cnt, 6);
    check_val("B_len_err", stat_len_err, 0);
    check_val("B_out_82_131", obs_b[82][131], 131);
    check_val("B_out_82_132", obs_b[82][132], 131);
    check_val("B_out_82_133", obs_b[82][133], 131);
    check_val("B_out_83_132", obs_b[83][132], 131);
    check_val("B_out_83_133", obs_b[83][133], 131);
    check_val("B_out_10_0_raw", obs_b[10][0], raw_10_0);
    check_val("B_tbad_10_0", bad_seen[1][10][0], 1);
    check_val("B_tbad_beats", bad_cnt_obs[1], 6);

    // Frame D: bypass, short line on row 3, aborted by a new tuser at row 40
    write_entry(0, 5, 5);
    write_entry(1, 2, 2);
    write_entry(2, 6, 6);
    gen_frame(2, 0, 3, 40, 0, 3);
    run_phase(100, 100);
    check_val("D_len_err", stat_len_err, 1);
    check_val("D_len_err_vs_model", stat_len_err, m_len_err);
    check_val("D_stat_held", stat_bad_cnt, 6);
    check_val("D_tbad_beats_bypass", bad_cnt_obs[2], 0);

    // Frame C: flag mode, unsorted table
    gen_frame(3, 1, 3, ROW, 0, -1);
    run_phase(100, 100);
    check_val("C_stat_bad_cnt", stat_bad_cnt, 2);
    check_val("C_len_err_sticky", stat_len_err, 1);
    check_val("C_tbad_beats", bad_cnt_obs[3], 2);
    check_val("C_tbad_5_5", bad_seen[3][5][5], 1);
    check_val("C_tbad_6_6", bad_seen[3][6][6], 1);
    check_val("C_tbad_2_2", bad_seen[3][2][2], 0);

    // Held output under stall, then reset drops it and clears status
    @(negedge axis_aclk);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = W'(123); s_axis_tuser = 1'b1; s_axis_tlast = 1'b0;
    cfg_mode = 2'd1; cfg_num = NW'(3);
    @(negedge axis_aclk);
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    @(negedge axis_aclk);
    #1;
    check_val("stall_m_tvalid", m_axis_tvalid, 1);
    check_val("stall_m_tdata_stable", m_axis_tdata, 123);
    check_val("stall_s_tready", s_axis_tready, 0);
    axis_areset = 1'b1;
    @(negedge axis_aclk);
    #1;
    check_val("mid_rst_m_tvalid", m_axis_tvalid, 0);
    check_val("mid_rst_stat_bad_cnt", stat_bad_cnt, 0);
    check_val("mid_rst_len_err", stat_len_err, 0);
    axis_areset   = 1'b0;
    m_axis_tready = 1'b1;
    m_stat = 0; m_len_err = 0;

    // Frame E: reserved mode acts as flag, table survived reset
    gen_frame(4, 3, 3, 8, 0, -1);
    run_phase(100, 100);
    check_val("E_tbad_beats", bad_cnt_obs[4], 2);
    check_val("E_tbad_6_6", bad_seen[4][6][6], 1);
    check_val("E_stat_vs_model", stat_bad_cnt, m_stat);
    check_val("E_len_err", stat_len_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bad_pixel_stream_mapper.md
BAD_PIXEL_STREAM_MAPPER -- requirements
Module: bad_pixel_stream_mapper

Interface
REQ-001 Parameter ROW, default 288, active lines per frame.
REQ-002 Parameter COL, default 384, pixels per line.
REQ-003 Parameter AXIS_TDATA_WIDTH, default 14, pixel width.
REQ-004 Parameter MAX_BAD, default 64, bad-pixel table depth (power of two, >=2); AW = clog2(MAX_BAD).
REQ-005 Port axis_aclk, in, 1: the single clock; reset is synchronous and active-high.
REQ-006 Port axis_areset, in, 1: synchronous active-high reset.
REQ-007 Ports s_axis_tvalid/tready/tdata/tuser/tlast, in/out/in/in/in, 1/1/AXIS_TDATA_WIDTH/1/1: pixel input; tuser marks first pixel of frame, tlast marks last pixel of line.
REQ-008 Ports m_axis_tvalid/tready/tdata/tuser/tlast, out/in/out/out/out, same widths: pixel output.
REQ-009 Port m_axis_tbad, out, 1: sideband, high on beats whose position matched a table entry.
REQ-010 Ports cfg_wr_en, cfg_wr_addr, cfg_wr_data, in, 1/AW/32: table write; data = {col[31:16], row[15:0]}.
REQ-011 Port cfg_num, in, AW+1: number of valid table entries.
REQ-012 Port cfg_mode, in, 2: 0 bypass, 1 flag only, 2 replace, 3 reserved (treated as 1).
REQ-013 Ports stat_bad_cnt (out, AW+1) and stat_len_err (out, 1): matches in the last completed frame; sticky line-length error.

Function
REQ-014 Output stage is one register; latency exactly 1 accepted beat; s_axis_tready = m_axis_tready OR NOT m_axis_tvalid.
REQ-015 Output stage holds tdata/tuser/tlast/tbad stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-016 Position counters: a tuser beat is (row 0, col 0); col increments per accepted beat; a tlast beat sets next col=0, row+1; row saturates at ROW-1.
REQ-017 tlast on col != COL-1, or col reaching COL-1 without tlast, sets stat_len_err until reset.
REQ-018 cfg_mode and cfg_num are sampled on the tuser beat and used for the whole frame; mid-frame changes have no effect until next tuser.
REQ-019 Table entries are in raster order; a pointer resets to entry 0 on the tuser beat and compares one entry per accepted beat.
REQ-020 Entry equal to position: beat is a match, pointer advances.
REQ-021 Entry behind position (raster index smaller, duplicate, or unsorted): no match, pointer advances one per accepted beat.
REQ-022 Pointer == frame cfg_num: no further matches that frame; cfg_num=0 yields no matches.
REQ-023 Mode 0: tbad=0, tdata passes unchanged. Mode 1: tbad per match, tdata unchanged.
REQ-024 Mode 2: matched beat at col>0 outputs the last output pixel of the same line (chains through adjacent bad pixels); matched beat at col 0 outputs raw tdata; tbad set in both cases.
REQ-025 stat_bad_cnt updates on the tlast beat of row ROW-1 with that frame's match count (saturating at MAX_BAD), else holds.
REQ-026 cfg_wr_en writes entry cfg_wr_addr on the same edge; a write to the entry being compared in that cycle takes effect next cycle.
REQ-027 tuser arriving mid-frame restarts counters, pointer and match count immediately (frame abort).

Reset
REQ-028 On axis_areset: m_axis_tvalid=0, tdata/tuser/tlast/tbad=0, counters 0, pointer 0, frame mode 0, stat_bad_cnt=0, stat_len_err=0.
REQ-029 Table contents are not cleared by reset; reset mid-frame drops the held output beat; the frame restarts at next tuser.

Structure
REQ-030 Shared package dpc_pkg holds the mode enum (BYPASS, FLAG, REPLACE), the entry field positions and the default geometry constants.
REQ-031 One sub-module, bad_pixel_table: MAX_BAD x 32 register file with one write port and one asynchronous read port.

Verification
REQ-032 Mode 1, table {(29,156),(82,132),(82,133),(83,132),(83,133)}, cfg_num=5, ramp image -> exactly 5 beats with tbad=1 at those positions, stat_bad_cnt=5, data unchanged.
REQ-033 Mode 2, same table, line 82 = col value -> out[82][132]=out[82][133]=131, out[83][132..133]=131.
REQ-034 Mode 2, entry (10,0) -> out[10][0]=raw, tbad=1.
REQ-035 Unsorted table {(5,5),(2,2),(6,6)} -> matches at (5,5),(6,6) only; stat_bad_cnt=2.
REQ-036 Random m_axis_tready (50% duty) -> output sequence identical to always-ready run, no dropped or duplicated beats.
REQ-037 tlast at col 100 of row 3 -> stat_len_err=1 and held; tuser at row 40 -> pointer/counters restart, next frame matches correct.
